// File: rtl/ps2_key_tracker.sv
// PS/2 set-2 scan-code tracker: pops bytes from the keyboard FIFO, decodes
// make/break/extended sequences, and reports the held key, ASCII and press count.
module ps2_key_tracker #(
  parameter int unsigned COUNT_MAX   = 99,
  parameter bit          ASCII_UPPER = 1'b0
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] ps2_data,
  input  logic       ps2_ready,
  input  logic       ps2_overflow,
  output logic       ps2_nextdata_n,
  output logic [7:0] key_code,
  output logic [7:0] key_ascii,
  output logic       key_ext,
  output logic       key_valid,
  output logic [7:0] key_count,
  output logic       err_overflow
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACK    = 2'd1,
    SETTLE = 2'd2
  } state_t;

  localparam logic [7:0] LP_CMAX   = 8'(COUNT_MAX);
  localparam logic [7:0] LP_LETTER = ASCII_UPPER ? 8'h41 : 8'h61;
  localparam logic [7:0] LP_DIGIT  = 8'h30;
  localparam logic [7:0] LP_EXT    = 8'hE0;
  localparam logic [7:0] LP_BRK    = 8'hF0;

  state_t     r_state;
  logic [7:0] r_byte;
  logic       r_ext_p;
  logic       r_brk_p;

  logic       w_same;
  logic [7:0] w_ascii;
  logic [7:0] w_count_nxt;

  // Set-2 scan code to ASCII for a-z and 0-9; anything else maps to 0x00.
  function automatic logic [7:0] f_lut(input logic [7:0] b);
    logic [7:0] v;
    v = '0;
    case (b)
      8'h1C: v = LP_LETTER + 8'd0;
      8'h32: v = LP_LETTER + 8'd1;
      8'h21: v = LP_LETTER + 8'd2;
      8'h23: v = LP_LETTER + 8'd3;
      8'h24: v = LP_LETTER + 8'd4;
      8'h2B: v = LP_LETTER + 8'd5;
      8'h34: v = LP_LETTER + 8'd6;
      8'h33: v = LP_LETTER + 8'd7;
      8'h43: v = LP_LETTER + 8'd8;
      8'h3B: v = LP_LETTER + 8'd9;
      8'h42: v = LP_LETTER + 8'd10;
      8'h4B: v = LP_LETTER + 8'd11;
      8'h3A: v = LP_LETTER + 8'd12;
      8'h31: v = LP_LETTER + 8'd13;
      8'h44: v = LP_LETTER + 8'd14;
      8'h4D: v = LP_LETTER + 8'd15;
      8'h15: v = LP_LETTER + 8'd16;
      8'h2D: v = LP_LETTER + 8'd17;
      8'h1B: v = LP_LETTER + 8'd18;
      8'h2C: v = LP_LETTER + 8'd19;
      8'h3C: v = LP_LETTER + 8'd20;
      8'h2A: v = LP_LETTER + 8'd21;
      8'h1D: v = LP_LETTER + 8'd22;
      8'h22: v = LP_LETTER + 8'd23;
      8'h35: v = LP_LETTER + 8'd24;
      8'h1A: v = LP_LETTER + 8'd25;
      8'h45: v = LP_DIGIT + 8'd0;
      8'h16: v = LP_DIGIT + 8'd1;
      8'h1E: v = LP_DIGIT + 8'd2;
      8'h26: v = LP_DIGIT + 8'd3;
      8'h25: v = LP_DIGIT + 8'd4;
      8'h2E: v = LP_DIGIT + 8'd5;
      8'h36: v = LP_DIGIT + 8'd6;
      8'h3D: v = LP_DIGIT + 8'd7;
      8'h3E: v = LP_DIGIT + 8'd8;
      8'h46: v = LP_DIGIT + 8'd9;
      default: v = '0;
    endcase
    return v;
  endfunction

  always_comb begin
    w_same      = key_valid && (r_byte == key_code) && (r_ext_p == key_ext);
    w_ascii     = r_ext_p ? '0 : f_lut(r_byte);
    w_count_nxt = (key_count == LP_CMAX) ? '0 : key_count + 8'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state        <= IDLE;
      r_byte         <= '0;
      r_ext_p        <= 1'b0;
      r_brk_p        <= 1'b0;
      ps2_nextdata_n <= 1'b1;
      key_code       <= '0;
      key_ascii      <= '0;
      key_ext        <= 1'b0;
      key_valid      <= 1'b0;
      key_count      <= '0;
      err_overflow   <= 1'b0;
    end else begin
      if (ps2_overflow) err_overflow <= 1'b1;
      case (r_state)
        IDLE: begin
          if (ps2_ready) begin
            r_byte         <= ps2_data;
            ps2_nextdata_n <= 1'b0;
            r_state        <= ACK;
          end
        end
        ACK: begin
          ps2_nextdata_n <= 1'b1;
          r_state        <= SETTLE;
          if (r_byte == LP_EXT) begin
            r_ext_p <= 1'b1;
          end else if (r_byte == LP_BRK) begin
            r_brk_p <= 1'b1;
          end else begin
            r_ext_p <= 1'b0;
            r_brk_p <= 1'b0;
            // Break only releases the matching held key; a repeated make is typematic.
            if (r_brk_p) begin
              if (w_same) key_valid <= 1'b0;
            end else if (!w_same) begin
              key_code  <= r_byte;
              key_ext   <= r_ext_p;
              key_valid <= 1'b1;
              key_ascii <= w_ascii;
              key_count <= w_count_nxt;
            end
          end
        end
        SETTLE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Scoreboard bench for ps2_key_tracker: a queue-backed upstream FIFO feeds bytes,
// a reference model predicts outputs per byte, compared after each pop.
module tb_ps2_key_tracker;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] ps2_data = '0;
  logic       ps2_ready = 1'b0;
  logic       ps2_overflow = 1'b0;
  logic       ps2_nextdata_n, u_nextdata_n;
  logic [7:0] key_code, key_ascii, key_count;
  logic       key_ext, key_valid, err_overflow;
  logic [7:0] u_code, u_ascii, u_count;
  logic       u_ext, u_valid, u_err;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  ps2_key_tracker #(.COUNT_MAX(99), .ASCII_UPPER(1'b0)) dut (
    .clk(clk), .resetn(resetn), .ps2_data(ps2_data), .ps2_ready(ps2_ready),
    .ps2_overflow(ps2_overflow), .ps2_nextdata_n(ps2_nextdata_n),
    .key_code(key_code), .key_ascii(key_ascii), .key_ext(key_ext),
    .key_valid(key_valid), .key_count(key_count), .err_overflow(err_overflow)
  );

  ps2_key_tracker #(.COUNT_MAX(99), .ASCII_UPPER(1'b1)) dut_up (
    .clk(clk), .resetn(resetn), .ps2_data(ps2_data), .ps2_ready(ps2_ready),
    .ps2_overflow(ps2_overflow), .ps2_nextdata_n(u_nextdata_n),
    .key_code(u_code), .key_ascii(u_ascii), .key_ext(u_ext),
    .key_valid(u_valid), .key_count(u_count), .err_overflow(u_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [7:0] m_code, m_asc, m_ascu, m_count;
  logic       m_ext, m_valid, m_extp, m_brkp;
  logic [7:0] fq[$];
  logic [33:0] exp_q[$];
  int n_sent = 0;
  int n_pulse = 0;
  int cyc = 0;
  int last_low = -100;
  bit pop_due = 0;

  function automatic logic [7:0] m_lut(input logic [7:0] b, input logic e, input logic up);
    logic [7:0] lc [26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,
                            8'h3B,8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,
                            8'h1B,8'h2C,8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
    logic [7:0] dc [10] = '{8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46};
    if (e) return 8'h00;
    for (int i = 0; i < 26; i++) if (lc[i] == b) return (up ? "A" : "a") + 8'(i);
    for (int i = 0; i < 10; i++) if (dc[i] == b) return "0" + 8'(i);
    return 8'h00;
  endfunction

  task automatic model_reset();
    m_code = '0; m_asc = '0; m_ascu = '0; m_count = '0;
    m_ext = 0; m_valid = 0; m_extp = 0; m_brkp = 0;
  endtask

  task automatic send(input logic [7:0] b);
    bit same;
    if (b == 8'hE0) m_extp = 1;
    else if (b == 8'hF0) m_brkp = 1;
    else begin
      same = m_valid && (b == m_code) && (m_extp == m_ext);
      if (m_brkp) begin
        if (same) m_valid = 0;
      end else if (!same) begin
        m_code = b; m_ext = m_extp; m_valid = 1;
        m_asc = m_lut(b, m_extp, 0); m_ascu = m_lut(b, m_extp, 1);
        m_count = (m_count == 8'd99) ? 8'd0 : m_count + 8'd1;
      end
      m_extp = 0; m_brkp = 0;
    end
    fq.push_back(b);
    exp_q.push_back({m_code, m_asc, m_ascu, m_ext, m_valid, m_count});
    n_sent++;
  endtask

  // Upstream FIFO emulation and scoreboard compare, all on the falling edge.
  initial begin
    logic [33:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (pop_due) begin
        pop_due = 0;
        if (fq.size() > 0) void'(fq.pop_front());
        if (exp_q.size() == 0) check("sb_empty", 64'(exp_q.size()), 64'd1);
        else begin
          e = exp_q.pop_front();
          check("sb_out", {30'd0, key_code, key_ascii, u_ascii, key_ext, key_valid, key_count},
                {30'd0, e});
        end
      end
      if (resetn && !ps2_nextdata_n) begin
        check("nd_gap", 64'(cyc - last_low >= 3), 64'd1);
        last_low = cyc;
        pop_due = 1;
        n_pulse++;
      end
      ps2_ready = (fq.size() != 0);
      ps2_data  = ps2_ready ? fq[0] : 8'h00;
    end
  end

  task automatic drain(input string tag);
    int k;
    k = 0;
    while ((fq.size() != 0 || exp_q.size() != 0) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clk);
    check({tag, "_pulses"}, 64'(n_pulse), 64'(n_sent));
  endtask

  task automatic do_reset();
    resetn = 0;
    #1;
    fq.delete(); exp_q.delete(); pop_due = 0;
    n_sent = 0; n_pulse = 0;
    model_reset();
    repeat (2) @(negedge clk);
    resetn = 1;
  endtask

  initial begin
    int k;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_nd", {63'd0, ps2_nextdata_n}, 64'd1);
    check("rst_outs", {key_code, key_ascii, key_count, key_ext, key_valid, err_overflow},
          64'd0);
    resetn = 1;
    @(negedge clk);

    send(8'h1C);
    drain("make1c");
    check("1c_code", 64'(key_code), 64'h1C);
    check("1c_ascii", 64'(key_ascii), 64'h61);
    check("1c_ascii_up", 64'(u_ascii), 64'h41);
    check("1c_count", 64'(key_count), 64'd1);
    send(8'hF0); send(8'h1C);
    drain("brk1c");
    check("brk1c_valid", {63'd0, key_valid}, 64'd0);
    check("brk1c_code", 64'(key_code), 64'h1C);

    do_reset();
    send(8'h1C); send(8'h1C); send(8'h1C);
    drain("typematic");
    check("typ_pulses", 64'(n_pulse), 64'd3);
    send(8'hF0); send(8'h1C);
    drain("typ_rel");
    check("typ_count", 64'(key_count), 64'd1);

    send(8'hE0); send(8'h75);
    drain("ext");
    check("ext_flag", {63'd0, key_ext}, 64'd1);
    check("ext_ascii", 64'(key_ascii), 64'h00);
    send(8'hF0); send(8'h75);
    drain("ext_plainbrk");
    check("ext_still", {63'd0, key_valid}, 64'd1);
    send(8'hE0); send(8'hF0); send(8'h75);
    drain("ext_brk");
    check("ext_rel", {63'd0, key_valid}, 64'd0);
    send(8'hE0); send(8'h75); send(8'hF0); send(8'hE0); send(8'h75);
    drain("ext_brk_swapped");
    check("ext_rel2", {63'd0, key_valid}, 64'd0);

    do_reset();
    send(8'h1C); send(8'h1B);
    drain("replace");
    check("rep_code", 64'(key_code), 64'h1B);
    check("rep_count", 64'(key_count), 64'd2);
    send(8'hF0); send(8'h1C);
    drain("rep_stale");
    check("rep_valid", {63'd0, key_valid}, 64'd1);
    send(8'h16); send(8'h45);
    drain("digits");
    check("digit0", 64'(key_ascii), 64'h30);

    do_reset();
    for (int i = 0; i < 99; i++) begin
      send(8'(i % 64 + 1)); send(8'hF0); send(8'(i % 64 + 1));
    end
    drain("wrap99");
    check("cnt99", 64'(key_count), 64'd99);
    send(8'h2B); send(8'hF0); send(8'h2B);
    drain("wrap100");
    check("cnt_wrap", 64'(key_count), 64'd0);
    check("cnt_wrap_up", 64'(u_count), 64'd0);

    // Overflow is sticky and parsing carries on.
    @(negedge clk); ps2_overflow = 1;
    @(negedge clk); ps2_overflow = 0;
    repeat (3) @(negedge clk);
    check("ovf_set", {62'd0, err_overflow, u_err}, 64'd3);
    send(8'h24);
    drain("ovf_parse");
    check("ovf_sticky", {63'd0, err_overflow}, 64'd1);

    // Reset while the pop strobe is low.
    send(8'h32);
    k = 0;
    while (ps2_nextdata_n && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("ack_reached", {63'd0, ps2_nextdata_n}, 64'd0);
    #2 resetn = 0;
    #1;
    check("ack_rst_nd", {63'd0, ps2_nextdata_n}, 64'd1);
    check("ack_rst_outs", {key_code, key_ascii, key_count, key_ext, key_valid, err_overflow},
          64'd0);
    fq.delete(); exp_q.delete(); pop_due = 0;
    n_sent = 0; n_pulse = 0;
    model_reset();
    repeat (2) @(negedge clk);
    resetn = 1;
    repeat (4) @(negedge clk);
    check("post_rst_idle", 64'(n_pulse), 64'd0);
    send(8'h4D);
    drain("post_rst");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
